// File: rtl/average_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | average_ctrl : sequencing for a triggered record averager (arm, capture,  |
// |                accumulate passes, stream the averaged record out).        |
// | Optional: AVERAGE_CTRL_MISSED_TRIG_EN adds the missed_trig counter port.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module average_ctrl #(
  parameter int RECORD_LEN = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_areset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           cfg_num_avg,
  input  logic                  trigger_in,
  input  logic                  s00_axis_tvalid,
  output logic                  s00_axis_tready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic                  acc_first,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  m00_axis_tready,
  output logic                  m00_axis_tvalid,
  output logic                  m00_axis_tlast,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic                  busy,
`ifdef AVERAGE_CTRL_MISSED_TRIG_EN
  output logic [15:0]           missed_trig,
`endif
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(RECORD_LEN - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_trig_prev;
  logic [15:0]             r_num_avg;
  logic [15:0]             r_pass;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [ADDR_WIDTH-1:0]   r_out_cnt;
  logic [ADDR_WIDTH:0]     r_rd_cnt;
  logic [1:0]              r_rd_pipe;
  logic [DATA_WIDTH-1:0]   r_fifo [3];
  logic [1:0]              r_fifo_wp;
  logic [1:0]              r_fifo_rp;
  logic [1:0]              r_fifo_cnt;
  logic                    r_done;

  logic                    w_trig_edge;
  logic                    w_start_acc;
  logic                    w_wr_en;
  logic                    w_last_write;
  logic [15:0]             w_pass_nxt;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_rd_en;
  logic [2:0]              w_credit;

  assign w_trig_edge     = trigger_in & ~r_trig_prev;
  assign w_start_acc     = (r_state == S_IDLE) & start & ~abort;
  assign s00_axis_tready = (r_state == S_CAPTURE);
  assign w_wr_en         = s00_axis_tvalid & s00_axis_tready;
  assign wr_en           = w_wr_en;
  assign wr_addr         = r_wr_addr;
  assign acc_first       = (r_state != S_IDLE) && (r_pass == 16'd0);
  assign w_last_write    = w_wr_en && (r_wr_addr == c_last_addr);
  assign w_pass_nxt      = r_pass + 16'd1;

  assign m00_axis_tvalid = (r_fifo_cnt != 2'd0);
  assign m00_axis_tdata  = r_fifo[r_fifo_rp];
  assign m00_axis_tlast  = m00_axis_tvalid && (r_out_cnt == c_last_addr);
  assign w_pop           = m00_axis_tvalid & m00_axis_tready;

  // The word leaving this cycle frees its slot, so a full pipe of three still
  // sustains one read per cycle while the FIFO can never exceed three entries.
  assign w_credit = {1'b0, r_fifo_cnt} - {2'b00, w_pop}
                  + {2'b00, r_rd_pipe[0]} + {2'b00, r_rd_pipe[1]};
  assign w_rd_en  = (r_state == S_READOUT) && !r_rd_cnt[ADDR_WIDTH] && !abort
                  && (w_credit < 3'd3);
  assign rd_en    = w_rd_en;
  assign rd_addr  = r_rd_cnt[ADDR_WIDTH-1:0];
  assign w_push   = r_rd_pipe[1] && (r_state == S_READOUT) && !abort;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (start) w_state_nxt = S_ARMED;
        S_ARMED:   if (w_trig_edge) w_state_nxt = S_CAPTURE;
        S_CAPTURE: if (w_last_write)
                     w_state_nxt = (w_pass_nxt == r_num_avg) ? S_READOUT : S_ARMED;
        S_READOUT: if (w_pop && m00_axis_tlast) w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_state     <= S_IDLE;
      r_trig_prev <= 1'b0;
      r_num_avg   <= 16'd0;
      r_pass      <= 16'd0;
      r_wr_addr   <= '0;
      r_out_cnt   <= '0;
      r_rd_cnt    <= '0;
      r_rd_pipe   <= 2'b00;
      r_fifo_wp   <= 2'd0;
      r_fifo_rp   <= 2'd0;
      r_fifo_cnt  <= 2'd0;
      r_done      <= 1'b0;
      for (int i = 0; i < 3; i++) r_fifo[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_trig_prev <= trigger_in;
      r_done      <= (r_state == S_READOUT) && w_pop && m00_axis_tlast && !abort;
      r_rd_pipe   <= {r_rd_pipe[0], w_rd_en};

      if (w_start_acc) begin
        r_num_avg <= (cfg_num_avg == 16'd0) ? 16'd1 : cfg_num_avg;
        r_pass    <= 16'd0;
      end else if ((r_state == S_CAPTURE) && w_last_write) begin
        r_pass <= w_pass_nxt;
      end

      if (r_state != S_CAPTURE)  r_wr_addr <= '0;
      else if (w_wr_en)          r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);

      if (r_state != S_READOUT)  r_rd_cnt <= '0;
      else if (w_rd_en)          r_rd_cnt <= r_rd_cnt + (ADDR_WIDTH+1)'(1);

      if (r_state != S_READOUT)  r_out_cnt <= '0;
      else if (w_pop)            r_out_cnt <= r_out_cnt + ADDR_WIDTH'(1);

      // Late read returns after an abort find the FIFO held empty and are dropped.
      if (abort || (r_state != S_READOUT)) begin
        r_fifo_wp  <= 2'd0;
        r_fifo_rp  <= 2'd0;
        r_fifo_cnt <= 2'd0;
      end else begin
        if (w_push) begin
          r_fifo[r_fifo_wp] <= rd_data;
          r_fifo_wp <= (r_fifo_wp == 2'd2) ? 2'd0 : r_fifo_wp + 2'd1;
        end
        if (w_pop) r_fifo_rp <= (r_fifo_rp == 2'd2) ? 2'd0 : r_fifo_rp + 2'd1;
        r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

`ifdef AVERAGE_CTRL_MISSED_TRIG_EN
  logic [15:0] r_missed;

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset || w_start_acc) begin
      r_missed <= 16'd0;
    end else if (w_trig_edge && ((r_state == S_CAPTURE) || (r_state == S_READOUT))
                 && (r_missed != 16'hFFFF)) begin
      r_missed <= r_missed + 16'd1;
    end
  end

  assign missed_trig = r_missed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_average_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_average_ctrl : self-checking bench for average_ctrl (RECORD_LEN=8).    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_average_ctrl;
  localparam int RL = 8;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int ST_IDLE = 0, ST_ARMED = 1, ST_CAPTURE = 2, ST_READOUT = 3;

  logic          clk = 1'b0;
  logic          rst, start, abort, trigger_in, s_tvalid, m_tready;
  logic [15:0]   cfg_num_avg;
  logic          s_tready, wr_en, acc_first, rd_en, m_tvalid, m_tlast, busy, done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] rd_data, rd_s1, m_tdata;
`ifdef AVERAGE_CTRL_MISSED_TRIG_EN
  logic [15:0]   missed_trig;
`endif

  always #5 clk = ~clk;

  average_ctrl #(.RECORD_LEN(RL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .start(start), .abort(abort),
    .cfg_num_avg(cfg_num_avg), .trigger_in(trigger_in), .s00_axis_tvalid(s_tvalid),
    .s00_axis_tready(s_tready), .wr_addr(wr_addr), .wr_en(wr_en), .acc_first(acc_first),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tlast(m_tlast), .m00_axis_tdata(m_tdata),
    .busy(busy),
`ifdef AVERAGE_CTRL_MISSED_TRIG_EN
    .missed_trig(missed_trig),
`endif
    .done(done));

  // RAM with two-cycle read latency; idle slots return a poison word
  logic [DW-1:0] ram [RL];
  always @(posedge clk) begin
    rd_s1   <= rd_en ? ram[rd_addr] : 32'hBAD0_BAD0;
    rd_data <= rd_s1;
  end

  int total = 0, bad = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int idx; int rem;} fly_t;
  int   m_st = ST_IDLE, m_num = 0, m_pass = 0, m_wr = 0, m_issued = 0, m_missed = 0;
  bit   m_prev = 0, m_done = 0;
  int   m_fifo[$];
  fly_t m_fly[$];
  int   m_to_armed = 0, m_ro_entries = 0;
  bit   e_busy, e_tready, e_wr_en, e_acc, e_tvalid, e_tlast, e_pop, e_rd_en, e_done;
  logic [DW-1:0] e_tdata;

  function automatic void calc();
    e_busy   = (m_st != ST_IDLE);
    e_tready = (m_st == ST_CAPTURE);
    e_wr_en  = e_tready && s_tvalid;
    e_acc    = e_busy && (m_pass == 0);
    e_tvalid = (m_fifo.size() > 0);
    e_tdata  = e_tvalid ? ram[m_fifo[0]] : '0;
    e_tlast  = e_tvalid && (m_fifo[0] == RL - 1);
    e_pop    = e_tvalid && m_tready;
    e_rd_en  = (m_st == ST_READOUT) && (m_issued < RL) && !abort &&
               ((m_fifo.size() - (e_pop ? 1 : 0) + m_fly.size()) < 3);
    e_done   = m_done;
  endfunction

  task automatic model_step();
    fly_t nf[$];
    bit   edge_seen;
    calc();
    if (rst) begin
      m_st = ST_IDLE; m_num = 0; m_pass = 0; m_wr = 0; m_issued = 0;
      m_prev = 0; m_done = 0; m_missed = 0;
      m_fifo.delete(); m_fly.delete();
      return;
    end
    if (e_pop) void'(m_fifo.pop_front());
    for (int i = 0; i < m_fly.size(); i++) begin
      if (m_fly[i].rem == 1) begin
        if (m_st == ST_READOUT && !abort) m_fifo.push_back(m_fly[i].idx);
      end else begin
        nf.push_back('{m_fly[i].idx, m_fly[i].rem - 1});
      end
    end
    m_fly = nf;
    if (e_rd_en) begin
      m_fly.push_back('{m_issued, 2});
      m_issued++;
    end
    m_done    = (m_st == ST_READOUT) && e_pop && e_tlast && !abort;
    edge_seen = trigger_in && !m_prev;
    m_prev    = trigger_in;
    if (m_st == ST_IDLE && start && !abort) m_missed = 0;
    else if (edge_seen && (m_st == ST_CAPTURE || m_st == ST_READOUT) && m_missed < 65535)
      m_missed++;
    if (abort) begin
      m_st = ST_IDLE;
      m_fifo.delete();
    end else begin
      case (m_st)
        ST_IDLE: if (start) begin
          m_st = ST_ARMED; m_num = (cfg_num_avg == 0) ? 1 : int'(cfg_num_avg); m_pass = 0;
        end
        ST_ARMED: if (edge_seen) begin m_st = ST_CAPTURE; m_wr = 0; end
        ST_CAPTURE: if (e_wr_en) begin
          if (m_wr == RL - 1) begin
            m_pass++;
            if (m_pass == m_num) begin m_st = ST_READOUT; m_issued = 0; m_ro_entries++; end
            else begin m_st = ST_ARMED; m_to_armed++; end
          end
          m_wr = (m_wr + 1) % RL;
        end
        default: if (e_pop && e_tlast) m_st = ST_IDLE;
      endcase
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end

  bit chk_en = 0;
  initial begin
    wait (chk_en);
    forever begin
      @(negedge clk);
      calc();
      chk("busy", busy, e_busy);
      chk("s_tready", s_tready, e_tready);
      chk("wr_en", wr_en, e_wr_en);
      if (e_tready) chk("wr_addr", wr_addr, m_wr);
      if (e_busy) chk("acc_first", acc_first, e_acc);
      chk("rd_en", rd_en, e_rd_en);
      if (e_rd_en) chk("rd_addr", rd_addr, m_issued);
      chk("m_tvalid", m_tvalid, e_tvalid);
      chk("m_tlast", m_tlast, e_tlast);
      if (e_tvalid) chk("m_tdata", m_tdata, e_tdata);
      chk("done", done, e_done);
`ifdef AVERAGE_CTRL_MISSED_TRIG_EN
      chk("missed_trig", missed_trig, m_missed);
`endif
    end
  end

  // ---------------- event monitor ----------------
  int cyc = 0, done_cnt = 0, accw_cnt = 0, wr_cnt = 0;
  int hs_q[$], rd_q[$], rdc_q[$];
  initial forever begin
    @(negedge clk);
    cyc++;
    if (m_tvalid && m_tready) hs_q.push_back(cyc);
    if (rd_en) begin rd_q.push_back(int'(rd_addr)); rdc_q.push_back(cyc); end
    if (done) done_cnt++;
    if (wr_en) begin wr_cnt++; if (acc_first) accw_cnt++; end
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(posedge clk); #1; endtask

  task automatic load_ram(int base);
    for (int i = 0; i < RL; i++) ram[i] = 32'(base * 256 + i * 17 + 5);
  endtask

  task automatic do_start(int cfg);
    cfg_num_avg = 16'(cfg); start = 1; step(); start = 0;
  endtask

  task automatic trig_pulse(); trigger_in = 1; step(); trigger_in = 0; endtask

  task automatic capture(int n); s_tvalid = 1; repeat (n) step(); s_tvalid = 0; endtask

  task automatic wait_done(int base, int max);
    int k = 0;
    while (done_cnt == base && k < max) begin step(); k++; end
    if (done_cnt == base) chk("done_timeout", 64'(k), 64'(max + 1));
    step(); step();
  endtask

  int b_hs, b_rd, b_done, b_acc, b_wr, b_arm, b_ro, k;
  int pat [4];

  task automatic snap();
    b_hs = hs_q.size(); b_rd = rd_q.size(); b_done = done_cnt;
    b_acc = accw_cnt; b_wr = wr_cnt; b_arm = m_to_armed; b_ro = m_ro_entries;
  endtask

  task automatic chk_order(string name);
    chk({name, "_reads"}, rd_q.size() - b_rd, RL);
    for (int i = 0; i < RL; i++)
      if (b_rd + i < rd_q.size()) chk({name, "_rd_addr"}, rd_q[b_rd + i], i);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; trigger_in = 0; s_tvalid = 0; m_tready = 1;
    cfg_num_avg = 16'd0;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    load_ram(1);
    step(); chk_en = 1; step();
    @(negedge clk);
    chk("rst_busy", busy, 0);      chk("rst_tready", s_tready, 0);
    chk("rst_wr_en", wr_en, 0);    chk("rst_acc_first", acc_first, 0);
    chk("rst_rd_en", rd_en, 0);    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);  chk("rst_done", done, 0);
    chk("rst_wr_addr", wr_addr, 0); chk("rst_rd_addr", rd_addr, 0);
    step(); rst = 0; step();

    // single pass, free-flowing readout
    snap();
    do_start(1); trig_pulse(); capture(RL); wait_done(b_done, 100);
    chk("t1_words", hs_q.size() - b_hs, RL);
    chk("t1_done", done_cnt - b_done, 1);
    chk("t1_accw", accw_cnt - b_acc, RL);
    chk_order("t1");
    if (hs_q.size() - b_hs >= RL && rdc_q.size() > b_rd) begin
      chk("t1_latency", hs_q[b_hs] - rdc_q[b_rd], 3);
      chk("t1_rate", hs_q[b_hs + RL - 1] - hs_q[b_hs], RL - 1);
    end

    // three passes; a stray start while armed is ignored
    load_ram(2); snap();
    do_start(3);
    for (int p = 0; p < 3; p++) begin
      trig_pulse(); capture(RL);
      if (p == 0) begin cfg_num_avg = 16'd5; start = 1; step(); start = 0; end
    end
    wait_done(b_done, 100);
    chk("t2_writes", wr_cnt - b_wr, 3 * RL);
    chk("t2_accw", accw_cnt - b_acc, RL);
    chk("t2_to_armed", m_to_armed - b_arm, 2);
    chk("t2_readouts", m_ro_entries - b_ro, 1);
    chk("t2_words", hs_q.size() - b_hs, RL);
    chk("t2_done", done_cnt - b_done, 1);

    // readout under tready 1,0,0,1 backpressure
    load_ram(3); snap();
    do_start(1); trig_pulse(); capture(RL);
    k = 0;
    while (done_cnt == b_done && k < 200) begin m_tready = pat[k % 4][0]; step(); k++; end
    m_tready = 1; step(); step();
    chk("t3_words", hs_q.size() - b_hs, RL);
    chk("t3_done", done_cnt - b_done, 1);
    chk_order("t3");

    // abort after three handshakes
    load_ram(4); snap();
    do_start(1); trig_pulse(); capture(RL);
    k = 0;
    while (hs_q.size() - b_hs < 3 && k < 50) begin step(); k++; end
    m_tready = 0; abort = 1; step(); abort = 0; m_tready = 1;
    @(negedge clk);
    chk("t4_tvalid", m_tvalid, 0);
    chk("t4_busy", busy, 0);
    repeat (10) step();
    chk("t4_words", hs_q.size() - b_hs, 3);
    chk("t4_no_done", done_cnt - b_done, 0);

    // abort beats start; abort out of ARMED
    start = 1; abort = 1; cfg_num_avg = 16'd2; step(); start = 0; abort = 0;
    @(negedge clk); chk("t5_abort_wins", busy, 0);
    do_start(2);
    @(negedge clk); chk("t5_armed_busy", busy, 1);
    abort = 1; step(); abort = 0;
    @(negedge clk); chk("t5_abort_armed", busy, 0);

    // reset in the middle of a readout
    snap();
    do_start(1); trig_pulse(); capture(RL);
    k = 0;
    while (hs_q.size() - b_hs < 2 && k < 50) begin step(); k++; end
    rst = 1; step(); rst = 0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_tvalid", m_tvalid, 0);
    repeat (8) step();
    chk("t6_no_done", done_cnt - b_done, 0);

    // cfg 0 acts as 1; stalled valid; trigger during capture is ignored
    load_ram(5); snap();
    do_start(0); trig_pulse();
    capture(3);
    trigger_in = 1; step(); trigger_in = 0; step();
    capture(RL - 3);
    wait_done(b_done, 100);
    chk("t7_writes", wr_cnt - b_wr, RL);
    chk("t7_words", hs_q.size() - b_hs, RL);
    chk("t7_done", done_cnt - b_done, 1);
    chk_order("t7");
`ifdef AVERAGE_CTRL_MISSED_TRIG_EN
    chk("t7_missed_trig", missed_trig, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/average_ctrl.md
AVERAGE_CTRL -- requirements
Module: average_ctrl

Interface
REQ-001 SHALL have parameter RECORD_LEN, default 1024, samples per trigger record (power of two, >=4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, equal to log2(RECORD_LEN).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, width of RAM words and output stream.
REQ-004 Ports SHALL be:
- s00_axis_aclk  in  1  sole clock; every output is driven from it.
- s00_axis_areset  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin an averaging run.
- abort  in  1  single-cycle request to cancel the run.
- cfg_num_avg  in  16  number of records to average; 0 means 1.
- trigger_in  in  1  level trigger; a rising edge arms capture.
- s00_axis_tvalid  in  1  ADC sample valid.
- s00_axis_tready  out  1  high only in CAPTURE.
- wr_addr  out  ADDR_WIDTH  accumulation RAM write address.
- wr_en  out  1  write strobe; equals s00_axis_tvalid & s00_axis_tready.
- acc_first  out  1  high during pass 0; the datapath stores the sample instead of adding it.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- rd_en  out  1  read issue strobe.
- rd_data  in  DATA_WIDTH  RAM read data, valid exactly 2 cycles after rd_en.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tvalid, m00_axis_tlast  out  1 each  output stream handshake.
- m00_axis_tdata  out  DATA_WIDTH  averaged record word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final readout handshake.

Function
REQ-005 States SHALL be IDLE, ARMED, CAPTURE and READOUT.
REQ-006 IDLE->ARMED on start; on that transition max(cfg_num_avg,1) SHALL be latched and the pass counter cleared; start SHALL be ignored outside IDLE.
REQ-007 A trigger edge SHALL be trigger_in & ~trigger_prev, with trigger_prev registered every cycle.
REQ-008 ARMED->CAPTURE on a trigger edge, with wr_addr=0; trigger edges outside ARMED SHALL be ignored.
REQ-009 In CAPTURE, each wr_en SHALL advance wr_addr by 1; a stalled tvalid SHALL hold wr_addr.
REQ-010 On wr_en at wr_addr=RECORD_LEN-1, the pass counter SHALL increment; if the new value equals the latched count, next state is READOUT, otherwise ARMED.
REQ-011 acc_first SHALL be 1 exactly while the pass counter is 0.
REQ-012 READOUT SHALL issue reads at rd_addr 0..RECORD_LEN-1 in order, each exactly once.
REQ-013 Returned data SHALL enter a 3-entry FIFO.
REQ-014 rd_en SHALL assert only when (FIFO occupancy + reads in flight) < 3; no word may be dropped under arbitrary m00_axis_tready.
REQ-015 m00_axis_tvalid SHALL equal FIFO non-empty, with tdata at the FIFO head; once asserted, tvalid and tdata SHALL hold until the handshake.
REQ-016 m00_axis_tlast SHALL be 1 only on word RECORD_LEN-1.
REQ-017 The tlast handshake SHALL cause READOUT->IDLE and a done pulse on the next cycle.
REQ-018 Minimum first-word latency SHALL be 3 cycles from READOUT entry; with tready held high, throughput SHALL be 1 word per cycle.
REQ-019 An abort in any state SHALL force IDLE on the next cycle and flush the FIFO; rd_data returning after an abort SHALL be discarded, and done SHALL not pulse.
REQ-020 When abort and start occur in the same cycle, abort SHALL win.

Reset
REQ-021 While s00_axis_areset is high at a clock edge, the state SHALL be IDLE and all counters, the FIFO and trigger_prev SHALL be 0.
REQ-022 After reset, all outputs SHALL be 0: tready, wr_en, acc_first, rd_en, tvalid, tlast, busy, done, and all addresses.
REQ-023 Reset during any state SHALL behave as abort, except that in-flight reads are also discarded.

Configuration
REQ-024 With AVERAGE_CTRL_MISSED_TRIG_EN defined, the block SHALL have output missed_trig[15:0]:
- counts trigger edges seen in CAPTURE or READOUT;
- saturates at 0xFFFF;
- clears on start and on reset.
REQ-025 Without the macro, the port SHALL be absent and no counter logic SHALL be generated.

Verification (RECORD_LEN=8, ADDR_WIDTH=3)
REQ-026 cfg_num_avg=1, start, trigger edge, 8 continuous valids -> wr_addr 0..7 with acc_first=1; 8 output words with tlast on the 8th; done pulses once.
REQ-027 cfg_num_avg=3, three trigger edges each followed by 8 valids -> acc_first high only for the first 8 writes; the state returns to ARMED twice; READOUT is entered once.
REQ-028 Readout with tready toggling 1,0,0,1 repeating -> exactly 8 words with rd_addr order 0..7, no duplicates or drops; tvalid/tdata stable while stalled.
REQ-029 Abort asserted in READOUT after 3 handshakes -> tvalid=0 and state IDLE on the next cycle; no done; later rd_data ignored.
REQ-030 cfg_num_avg=0 -> behaves as 1; trigger edge during CAPTURE -> no restart, and missed_trig=1 when the macro is defined.
